// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single async-FIFO write port among NUM_REQ w_clk-domain requesters.
// Define ARB_SRC_TAG_EN to prefix every FIFO word with the granted requester index.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      w_clk,
  input  logic                      wrst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_req,
`ifdef ARB_SRC_TAG_EN
  output logic [DATA_W+ID_W-1:0]    fifo_data_in,
`else
  output logic [DATA_W-1:0]         fifo_data_in,
`endif
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam int         CW    = ID_W + 1;

  logic [0:0]      state_r;
  logic [ID_W-1:0] rr_ptr_r;
  logic [3:0]      beat_cnt_r;

  logic            pick_found_s;
  logic [ID_W-1:0] pick_id_s;
  logic [CW-1:0]   cand_s;
  logic            g_valid_s;
  logic [DATA_W-1:0] g_data_s;
  logic            wr_s;
  logic            last_beat_s;
  logic [ID_W-1:0] next_ptr_s;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    pick_found_s = 1'b0;
    pick_id_s    = '0;
    cand_s       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = CW'(rr_ptr_r) + CW'(k);
      if (cand_s >= CW'(NUM_REQ)) begin
        cand_s = cand_s - CW'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!pick_found_s && req_valid[cand_s[ID_W-1:0]]) begin
        pick_found_s = 1'b1;
        pick_id_s    = cand_s[ID_W-1:0];
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Write path: only the granted requester sees ready, every write is gated by fifo_full.
  always_comb begin
    g_valid_s   = req_valid[grant_id];
    g_data_s    = req_data[int'(grant_id)*DATA_W +: DATA_W];
    wr_s        = busy & g_valid_s & ~fifo_full;
    last_beat_s = (beat_cnt_r == 4'(MAX_BURST - 1));
    fifo_wr_req = wr_s;
    req_ready   = '0;
    if (state_r == GRANT) begin
      req_ready[grant_id] = ~fifo_full;
    end else begin
      req_ready = '0;
    end
    if (grant_id == ID_W'(NUM_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_id + ID_W'(1);
    end
    if (busy) begin
`ifdef ARB_SRC_TAG_EN
      fifo_data_in = {grant_id, g_data_s};
`else
      fifo_data_in = g_data_s;
`endif
    end else begin
      fifo_data_in = '0;
    end
  end

  assign busy = (state_r == GRANT);

  // Arbitration FSM: one IDLE cycle to pick, then hold the grant for up to MAX_BURST beats.
  always_ff @(posedge w_clk or negedge wrst) begin
    if (!wrst) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      beat_cnt_r <= 4'd0;
      grant_id   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            grant_id   <= pick_id_s;
            beat_cnt_r <= 4'd0;
            state_r    <= GRANT;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          // A dropped valid ends the burst even if it coincides with the last beat.
          if (!g_valid_s) begin
            state_r  <= IDLE;
            rr_ptr_r <= next_ptr_s;
          end else if (wr_s) begin
            beat_cnt_r <= beat_cnt_r + 4'd1;
            if (last_beat_s) begin
              state_r  <= IDLE;
              rr_ptr_r <= next_ptr_s;
            end else begin
              state_r <= GRANT;
            end
          end else begin
            state_r <= GRANT;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=8, MAX_BURST=4); write log collected on negedge.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;
`ifdef ARB_SRC_TAG_EN
  localparam int OUT_W = DATA_W + ID_W;
`else
  localparam int OUT_W = DATA_W;
`endif

  logic                      w_clk = 1'b0;
  logic                      wrst  = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full = 1'b0;
  logic                      fifo_wr_req;
  logic [OUT_W-1:0]          fifo_data_in;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int multi_hot = 0;
  logic [OUT_W-1:0] wq[$];
  logic [ID_W-1:0]  gq[$];
  int               wc[$];
  logic [7:0] next_d [NUM_REQ];
  int         remaining [NUM_REQ];

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .w_clk(w_clk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_req(fifo_wr_req),
    .fifo_data_in(fifo_data_in), .grant_id(grant_id), .busy(busy)
  );

  always #5 w_clk = ~w_clk;

  // Log every FIFO write with its grant and cycle number.
  always @(negedge w_clk) begin
    cyc <= cyc + 1;
    if (wrst && fifo_wr_req) begin
      wq.push_back(fifo_data_in);
      gq.push_back(grant_id);
      wc.push_back(cyc);
    end
    if ($countones(req_ready) > 1) multi_hot <= multi_hot + 1;
  end

  function automatic logic [OUT_W-1:0] exp_word(input int id, input logic [7:0] d);
`ifdef ARB_SRC_TAG_EN
    return {2'(id), d};
`else
    return d;
`endif
  endfunction

  task automatic apply();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = (remaining[i] > 0);
      req_data[i*DATA_W +: DATA_W] = next_d[i];
    end
  endtask

  // One cycle: note accepted beats at negedge, advance each accepted source after the edge.
  task automatic step();
    logic [NUM_REQ-1:0] acc;
    @(negedge w_clk);
    acc = req_valid & req_ready;
    @(posedge w_clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        remaining[i] = remaining[i] - 1;
        next_d[i] = next_d[i] + 8'd1;
      end
    end
    apply();
  endtask

  task automatic clear_log();
    wq.delete();
    gq.delete();
    wc.delete();
  endtask

  task automatic do_reset();
    wrst = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;
    apply();
    @(posedge w_clk);
    #1;
    wrst = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      remaining[i] = 0;
      next_d[i] = 8'h00;
    end
    apply();
    #1 wrst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || fifo_wr_req !== 1'b0 || req_ready !== 4'b0000 ||
        grant_id !== 2'd0 || fifo_data_in !== '0) begin
      errors++;
      $display("FAIL reset_vals: busy=%b wr=%b ready=%b gid=%0d data=%0h, required all zero",
               busy, fifo_wr_req, req_ready, grant_id, fifo_data_in);
    end
    @(posedge w_clk);
    #1 wrst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge w_clk);
      checks++;
      if (busy !== 1'b0 || fifo_wr_req !== 1'b0 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL idle_quiet c%0d: busy=%b wr=%b ready=%b, required 0/0/0000",
                 c, busy, fifo_wr_req, req_ready);
      end
    end
    @(posedge w_clk);
    #1;
  endtask

  task automatic test_single();
    do_reset();
    remaining[1] = 8;
    next_d[1] = 8'h10;
    apply();
    for (int s = 0; s < 12; s++) step();
    checks++;
    if (wq.size() != 8) begin
      errors++;
      $display("FAIL single_count: got %0d writes, required 8", wq.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wq[i] !== exp_word(1, 8'(16 + i)) || gq[i] !== 2'd1) begin
          errors++;
          $display("FAIL single_beat%0d: got data %0h id %0d, required %0h id 1",
                   i, wq[i], gq[i], exp_word(1, 8'(16 + i)));
        end
      end
      checks++;
      if (wc[3] - wc[0] != 3 || wc[4] - wc[3] != 2) begin
        errors++;
        $display("FAIL single_gap: burst span %0d gap %0d, required 3 and 2",
                 wc[3] - wc[0], wc[4] - wc[3]);
      end
    end
  endtask

  task automatic test_two();
    do_reset();
    remaining[0] = 100; next_d[0] = 8'h00;
    remaining[2] = 100; next_d[2] = 8'h80;
    apply();
    for (int s = 0; s < 20; s++) step();
    remaining[0] = 0;
    remaining[2] = 0;
    apply();
    checks++;
    if (wq.size() != 16) begin
      errors++;
      $display("FAIL rr_count: got %0d writes, required 16", wq.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        int g;
        int id;
        logic [7:0] d;
        g  = i / 4;
        id = (g % 2 == 0) ? 0 : 2;
        d  = 8'(((id == 0) ? 8'h00 : 8'h80) + (g / 2) * 4 + (i % 4));
        checks++;
        if (wq[i] !== exp_word(id, d) || gq[i] !== 2'(id)) begin
          errors++;
          $display("FAIL rr_beat%0d: got data %0h id %0d, required %0h id %0d",
                   i, wq[i], gq[i], exp_word(id, d), id);
        end
      end
    end
    checks++;
    if (multi_hot != 0) begin
      errors++;
      $display("FAIL rr_onehot: got %0d multi-ready cycles, required 0", multi_hot);
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    remaining[3] = 4;
    next_d[3] = 8'h30;
    apply();
    for (int s = 0; s < 3; s++) step();
    fifo_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #2;
      checks++;
      if (fifo_wr_req !== 1'b0 || req_ready[3] !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd3) begin
        errors++;
        $display("FAIL stall_c%0d: wr=%b ready3=%b busy=%b gid=%0d, required 0/0/1/3",
                 s, fifo_wr_req, req_ready[3], busy, grant_id);
      end
      step();
    end
    fifo_full = 1'b0;
    for (int s = 0; s < 4; s++) step();
    checks++;
    if (wq.size() != 4) begin
      errors++;
      $display("FAIL stall_count: got %0d writes, required 4", wq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wq[i] !== exp_word(3, 8'(48 + i)) || gq[i] !== 2'd3) begin
          errors++;
          $display("FAIL stall_beat%0d: got data %0h id %0d, required %0h id 3",
                   i, wq[i], gq[i], exp_word(3, 8'(48 + i)));
        end
      end
      checks++;
      if (wc[2] - wc[1] != 6) begin
        errors++;
        $display("FAIL stall_gap: got %0d cycles between beats 2 and 3, required 6", wc[2] - wc[1]);
      end
    end
  endtask

  task automatic test_drop();
    logic [7:0] ed [4];
    logic [1:0] eg [4];
    ed[0] = 8'h50; ed[1] = 8'h51; ed[2] = 8'h60; ed[3] = 8'h61;
    eg[0] = 2'd1;  eg[1] = 2'd1;  eg[2] = 2'd2;  eg[3] = 2'd2;
    do_reset();
    remaining[1] = 2; next_d[1] = 8'h50;
    remaining[2] = 2; next_d[2] = 8'h60;
    apply();
    for (int s = 0; s < 8; s++) step();
    checks++;
    if (wq.size() != 4) begin
      errors++;
      $display("FAIL drop_count: got %0d writes, required 4", wq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wq[i] !== exp_word(int'(eg[i]), ed[i]) || gq[i] !== eg[i]) begin
          errors++;
          $display("FAIL drop_beat%0d: got data %0h id %0d, required %0h id %0d",
                   i, wq[i], gq[i], exp_word(int'(eg[i]), ed[i]), eg[i]);
        end
      end
      checks++;
      if (wc[2] - wc[1] != 3) begin
        errors++;
        $display("FAIL drop_gap: got %0d cycles, required 3", wc[2] - wc[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    remaining[2] = 4; next_d[2] = 8'h20;
    apply();
    for (int s = 0; s < 5; s++) step();
    remaining[0] = 8; next_d[0] = 8'h70;
    apply();
    for (int s = 0; s < 3; s++) step();
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midburst_pre: busy=%b gid=%0d ready=%b, required 1/0/0001", busy, grant_id, req_ready);
    end
    wrst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || fifo_wr_req !== 1'b0 || req_ready !== 4'b0000 ||
        grant_id !== 2'd0 || fifo_data_in !== '0) begin
      errors++;
      $display("FAIL midburst_async: busy=%b wr=%b ready=%b gid=%0d data=%0h, required all zero",
               busy, fifo_wr_req, req_ready, grant_id, fifo_data_in);
    end
    remaining[3] = 4; next_d[3] = 8'hA0;
    apply();
    clear_log();
    @(posedge w_clk);
    #1 wrst = 1'b1;
    for (int s = 0; s < 2; s++) step();
    checks++;
    if (wq.size() < 1) begin
      errors++;
      $display("FAIL post_reset_write: got 0 writes, required 1");
    end else if (wq[0] !== exp_word(0, 8'h72) || gq[0] !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_grant: got data %0h id %0d, required %0h id 0",
               wq[0], gq[0], exp_word(0, 8'h72));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_full_stall();
    test_drop();
    test_reset_mid();
    checks++;
    if (multi_hot != 0) begin
      errors++;
      $display("FAIL onehot_global: got %0d multi-ready cycles, required 0", multi_hot);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
